// File: rtl/sc_mac_et.sv
// sc_mac_et: stochastic-computing multiply-accumulate with early termination.
// Each RUN cycle ANDs N bitstream pairs, picks one product with a round-robin
// select, counts the ones and ends the run as soon as the threshold decision
// is settled (or the full stream length has been consumed).
module sc_mac_et #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len_i,
  input  logic [CW-1:0] thr_i,
  input  logic          et_en_i,
  input  logic [2*N-1:0] x_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          z_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] cycles_o,
  output logic          dec_o,
  output logic          et_o
);

  localparam int SW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] len_q;
  logic [CW-1:0] thr_q;
  logic          et_en_q;
  logic [SW-1:0] sel;
  logic [CW-1:0] count_q;
  logic [CW-1:0] cycles_q;
  logic          z_q;
  logic          dec_q;
  logic          et_q;
  logic          done_q;

  logic [N-1:0]  prod;
  logic          bit_sel;
  logic [CW-1:0] count_n;
  logic [CW-1:0] cycles_n;
  logic [CW-1:0] remaining;
  logic          end_run;
  logic          end_dec;
  logic          end_et;

  // Per-pair products and the round-robin selected bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    prod = '0;
    for (int k = 0; k < N; k++) begin
      prod[k] = x_i[2*k] & x_i[2*k+1];
    end
    bit_sel = prod[sel];
  end

  // Next-count values; count + remaining never exceeds L, so CW bits suffice.
  assign count_n   = count_q + {{(CW-1){1'b0}}, bit_sel};
  assign cycles_n  = cycles_q + {{(CW-1){1'b0}}, 1'b1};
  assign remaining = len_q - cycles_n;

  // Termination decision on the post-update values, natural end first.
  always_comb begin
    end_run = 1'b0;
    end_dec = 1'b0;
    end_et  = 1'b0;
    if (cycles_n == len_q) begin
      end_run = 1'b1;
      end_dec = (count_n >= thr_q);
    end else if (et_en_q && (count_n >= thr_q)) begin
      end_run = 1'b1;
      end_dec = 1'b1;
      end_et  = 1'b1;
    end else if (et_en_q && ((count_n + remaining) < thr_q)) begin
      end_run = 1'b1;
      end_et  = 1'b1;
    end
  end

  // Control FSM and datapath registers; done_q is a one-cycle entry pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      thr_q    <= '0;
      et_en_q  <= 1'b0;
      sel      <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      z_q      <= 1'b0;
      dec_q    <= 1'b0;
      et_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q    <= len_i;
            thr_q    <= thr_i;
            et_en_q  <= et_en_i;
            sel      <= '0;
            count_q  <= '0;
            cycles_q <= '0;
            z_q      <= 1'b0;
            et_q     <= 1'b0;
            if (len_i == '0) begin
              // Empty stream: decision is just whether T is zero.
              state  <= S_DONE;
              done_q <= 1'b1;
              dec_q  <= (thr_i == '0);
            end else begin
              state <= S_RUN;
              dec_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          z_q      <= bit_sel;
          count_q  <= count_n;
          cycles_q <= cycles_n;
          sel      <= sel + {{(SW-1){1'b0}}, 1'b1};
          if (end_run) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            dec_q  <= end_dec;
            et_q   <= end_et;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (state == S_RUN);
  assign done_o   = done_q;
  assign z_o      = z_q;
  assign count_o  = count_q;
  assign cycles_o = cycles_q;
  assign dec_o    = dec_q;
  assign et_o     = et_q;

endmodule

// File: tb/tb_sc_mac_et.sv
// Directed bench for sc_mac_et (N=4, CW=8): a vector table of complete runs
// plus hand-written sequences for rotation, mid-run start, reset and
// back-to-back starts.
module tb_sc_mac_et;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int BOUND = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len_i;
  logic [CW-1:0] thr_i;
  logic          et_en_i;
  logic [2*N-1:0] x_i;
  logic          busy_o;
  logic          done_o;
  logic          z_o;
  logic [CW-1:0] count_o;
  logic [CW-1:0] cycles_o;
  logic          dec_o;
  logic          et_o;

  int checks   = 0;
  int failures = 0;

  sc_mac_et #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len_i    (len_i),
    .thr_i    (thr_i),
    .et_en_i  (et_en_i),
    .x_i      (x_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .z_o      (z_o),
    .count_o  (count_o),
    .cycles_o (cycles_o),
    .dec_o    (dec_o),
    .et_o     (et_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic [7:0] thr;
    logic       et_en;
    logic [7:0] x;
    int         edges;
    logic [7:0] count;
    logic [7:0] cycles;
    logic       dec;
    logic       et;
    logic       z;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Set up run inputs at a falling edge, then launch.
  task automatic do_start(input logic [7:0] len, input logic [7:0] thr,
                          input logic et, input logic [7:0] x);
    @(negedge clk);
    len_i = len; thr_i = thr; et_en_i = et; x_i = x; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after E0 until done_o is seen (0 for the L=0 case).
  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int n, input vec_t v);
    check({tag, " edges"},  n, v.edges);
    check({tag, " done"},   done_o, 1'b1);
    check({tag, " busy"},   busy_o, 1'b0);
    check({tag, " count"},  count_o, v.count);
    check({tag, " cycles"}, cycles_o, v.cycles);
    check({tag, " dec"},    dec_o, v.dec);
    check({tag, " et"},     et_o, v.et);
    check({tag, " z"},      z_o, v.z);
  endtask

  int   n;
  int   n2;
  int   done_seen;
  vec_t v;

  initial begin
    // len thr et x edges count cycles dec et z
    vecs[0]  = '{8'd16,  8'd8,   1'b0, 8'hFF, 16,  8'd16,  8'd16,  1'b1, 1'b0, 1'b1};
    vecs[1]  = '{8'd16,  8'd8,   1'b0, 8'h30, 16,  8'd4,   8'd16,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'd100, 8'd5,   1'b1, 8'hFF, 5,   8'd5,   8'd5,   1'b1, 1'b1, 1'b1};
    vecs[3]  = '{8'd20,  8'd10,  1'b1, 8'h00, 11,  8'd0,   8'd11,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'd12,  8'd12,  1'b1, 8'hFF, 12,  8'd12,  8'd12,  1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'd0,   8'd0,   1'b0, 8'hFF, 0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'd0,   8'd3,   1'b1, 8'hFF, 0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'd10,  8'd0,   1'b1, 8'h00, 1,   8'd0,   8'd1,   1'b1, 1'b1, 1'b0};
    vecs[8]  = '{8'd8,   8'd3,   1'b0, 8'hED, 8,   8'd4,   8'd8,   1'b1, 1'b0, 1'b1};
    vecs[9]  = '{8'd8,   8'd3,   1'b1, 8'hED, 6,   8'd3,   8'd6,   1'b1, 1'b1, 1'b1};
    vecs[10] = '{8'd8,   8'd6,   1'b1, 8'hED, 5,   8'd2,   8'd5,   1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'd1,   8'd0,   1'b1, 8'h00, 1,   8'd0,   8'd1,   1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'd255, 8'd255, 1'b0, 8'hFF, 255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; len_i = '0; thr_i = '0; et_en_i = 1'b0; x_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   busy_o,   1'b0);
    check("reset done",   done_o,   1'b0);
    check("reset count",  count_o,  '0);
    check("reset cycles", cycles_o, '0);
    check("reset dec",    dec_o,    1'b0);
    check("reset et",     et_o,     1'b0);
    check("reset z",      z_o,      1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven complete runs; each one also checks that results hold.
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      do_start(v.len, v.thr, v.et_en, v.x);
      wait_done(n);
      check_result($sformatf("vec%0d", i), n, v);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done pulse", i), done_o, 1'b0);
      check($sformatf("vec%0d hold count", i), count_o, v.count);
      check($sformatf("vec%0d hold dec", i), dec_o, v.dec);
    end

    // Select rotation: only pair 2 active, ones on bits 3, 7, 11, 15.
    do_start(8'd16, 8'd8, 1'b0, 8'h30);
    check("rot busy after E0", busy_o, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("rot z bit%0d", j), z_o, (j % 4) == 3);
    end
    check("rot done", done_o, 1'b1);
    check("rot count", count_o, 8'd4);

    // Start pulsed mid-run must be ignored.
    do_start(8'd16, 8'd8, 1'b0, 8'hFF);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    len_i = 8'd3; thr_i = 8'd1; et_en_i = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("midstart busy", busy_o, 1'b1);
    check("midstart count", count_o, 8'd6);
    wait_done(n2);
    check("midstart edges", 6 + n2, 16);
    check("midstart count end", count_o, 8'd16);
    check("midstart et", et_o, 1'b0);

    // Reset during a run: everything clears, no done pulse follows.
    do_start(8'd16, 8'd8, 1'b0, 8'hFF);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("prerst count", count_o, 8'd5);
    #3 rst = 1'b1;
    #1;
    check("rst busy",   busy_o,   1'b0);
    check("rst count",  count_o,  '0);
    check("rst cycles", cycles_o, '0);
    check("rst z",      z_o,      1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) done_seen++;
    end
    check("rst no done", done_seen, 0);

    // Following run starts cleanly from zero.
    do_start(8'd4, 8'd2, 1'b0, 8'hFF);
    wait_done(n);
    check("post-rst edges", n, 4);
    check("post-rst count", count_o, 8'd4);
    check("post-rst dec", dec_o, 1'b1);

    // Back-to-back: start accepted in the done_o cycle.
    len_i = 8'd3; thr_i = 8'd3; et_en_i = 1'b0; x_i = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b busy", busy_o, 1'b1);
    check("b2b count clr", count_o, '0);
    wait_done(n);
    check("b2b edges", n, 3);
    check("b2b count", count_o, 8'd0);
    check("b2b dec", dec_o, 1'b0);
    check("b2b et", et_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_mac_et.md
# sc_mac_et

Parametrised stochastic-computing multiply-accumulate with early termination. Each cycle it ANDs N pairs of input bitstream bits and selects one product with an internal round-robin counter. The output is an unbiased stream of (1/N)·Σ(a_k·b_k), and the block counts its ones. A threshold decision is formed, and the run stops early once that decision can no longer change, so a fixed-length run is not required. It sits after the SNG/bitstream-generation stage and feeds the result/controller logic in the early-termination apps.

## Interface
Parameters:
- N, default 4: number of product pairs; power of two, N ≥ 2.
- CW, default 8: width of the length, threshold and count values; maximum stream length is 2^CW−1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE, ignored in RUN.
- len_i  in  CW  stream length L in bits; latched on start.
- thr_i  in  CW  decision threshold T in ones; latched on start.
- et_en_i  in  1  enable early termination; latched on start.
- x_i  in  2N  stream bits; pair k is x_i[2k] (a_k) and x_i[2k+1] (b_k).
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse on entry to DONE.
- z_o  out  1  registered product bit selected in the last RUN cycle.
- count_o  out  CW  ones accumulated so far.
- cycles_o  out  CW  stream bits consumed so far.
- dec_o  out  1  threshold decision: 1 means count ≥ T.
- et_o  out  1  run ended before L bits.

## Operation
- Three states: IDLE, RUN and DONE. Reset enters IDLE with every output at 0 and the select counter sel at 0.
- start in IDLE or DONE:
  - Latch L, T and et_en.
  - Clear count, cycles, sel, z_o, dec_o and et_o.
  - Go to RUN. If L = 0, go straight to DONE instead, with count = 0, et_o = 0 and dec_o = (T == 0).
- Each RUN cycle:
  - p_k = a_k & b_k, and b = p_sel.
  - z_o ← b; count' = count + b; cycles' = cycles + 1; sel ← sel + 1 (mod N).
  - Termination is evaluated on the primed values, in this priority order:
    1. If cycles' == L: natural end, dec_o = (count' ≥ T), et_o = 0.
    2. Else if et_en and count' ≥ T: early end, dec_o = 1, et_o = 1.
    3. Else if et_en and count' + (L − cycles') < T: early end, dec_o = 0, et_o = 1.
    4. Otherwise stay in RUN.
  - On any end, go to DONE.
- Arithmetic: count ≤ cycles ≤ L ≤ 2^CW−1, and count + (L − cycles) ≤ L. All arithmetic is unsigned CW-bit with no overflow and no saturation logic.
- DONE holds count_o, cycles_o, dec_o, et_o and z_o stable until the next start or reset. done_o is high only in the first DONE cycle.
- start while in RUN is ignored; latched parameters do not change mid-run.
- Reset asserted mid-run aborts the run immediately and clears all state; no done_o is produced.

## Timing
- Start is sampled at edge E0. x_i is sampled at edges E1 through Ek, where k ≤ L is the terminating bit.
- busy_o is high from after E0 until after Ek.
- done_o is high for exactly the cycle following Ek; results are valid from that same cycle.
- L = 0: done_o is high in the cycle after E0.
- Back-to-back runs: a start in the done_o cycle is accepted, giving one idle-free turnaround.
- T = 0 with et_en = 1: terminates after the first bit with dec_o = 1 and et_o = 1 (only when L > 1).

## Test plan
- N=4, L=16, T=8, et_en=0, x_i all ones -> done_o after E16; count 16, cycles 16, dec 1, et 0.
- Select rotation: only pair 2 all ones, others 0, L=16, et_en=0 -> count 4, with z_o = 1 on sel=2 cycles only (bits 3, 7, 11, 15).
- Early high: et_en=1, all ones, T=5, L=100 -> done_o after E5; count 5, cycles 5, dec 1, et 1.
- Early low: et_en=1, all zeros, T=10, L=20 -> done_o after E11; count 0, cycles 11, dec 0, et 1.
- Priority at the boundary: et_en=1, all ones, T=L=12 -> ends at E12 with et 0, dec 1.
- Corner cases:
  - L=0 gives done_o the next cycle with dec = (T == 0).
  - start pulsed mid-run is ignored; count continues.
  - rst at E6 of an L=16 run returns to IDLE with all outputs 0 and no done_o.
  - A following start runs cleanly from count 0.
